// File: rtl/instr_decode_pipe_pkg.sv
// Shared RV32I decode definitions: opcode constants, format codes and the default datapath width.
package instr_decode_pipe_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FmtR = 3'd0,
        FmtI = 3'd1,
        FmtS = 3'd2,
        FmtB = 3'd3,
        FmtU = 3'd4,
        FmtJ = 3'd5
    } fmt_e;

endpackage

// File: rtl/instr_decode_pipe_imm_gen.sv
// Combinational RV32I format classifier and sign-extended immediate generator.
module instr_decode_pipe_imm_gen
    import instr_decode_pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic signed [31:0] imm32;

    always_comb begin
        fmt     = FmtR;
        illegal = 1'b0;
        imm32   = '0;
        case (instr[6:0])
            OP_OP: fmt = FmtR;
            OP_OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt   = FmtI;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt   = FmtS;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FmtB;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FmtU;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FmtJ;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: illegal = 1'b1;
        endcase
        // Compressed/reserved encodings never match a listed opcode, but keep the rule explicit.
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
            fmt     = FmtR;
            imm32   = '0;
        end
        imm = XLEN'(imm32);
    end

endmodule

// File: rtl/instr_decode_pipe.sv
// One-cycle RV32I decode stage with a main output register and a skid register.
module instr_decode_pipe
    import instr_decode_pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t dec;
    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   in_ready_q;
    logic   accept, consume;

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    instr_decode_pipe_imm_gen #(
        .XLEN (XLEN)
    ) imm_gen (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec.opcode  = in_instr[6:0];
        dec.funct3  = in_instr[14:12];
        dec.funct7  = in_instr[31:25];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd      = in_instr[11:7];
        dec.imm     = dec_imm;
        dec.fmt     = dec_fmt;
        dec.illegal = dec_illegal;
        dec.pc      = in_pc;
    end

    assign accept  = in_valid && in_ready_q && !flush;
    assign consume = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume && skid_valid_q) begin
            // in_ready is low whenever the skid is full, so no new accept can collide here.
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else if (consume || !main_valid_q) begin
            main_valid_d = accept;
            if (accept) begin
                main_d = dec;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_opcode  = main_q.opcode;
    assign out_funct3  = main_q.funct3;
    assign out_funct7  = main_q.funct7;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_pc      = main_q.pc;

endmodule

// File: doc/instr_decode_pipe.md
INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width of the imm and pc fields; legal values are 32 and 64.
REQ-002 Parameter PC_W, default 32, meaning width of the pc sideband carried with each instruction.
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port in_valid  in  1  an instruction is offered.
REQ-006 Port in_ready  out  1  the block accepts the instruction this cycle.
REQ-007 Port in_instr  in  32  raw RV32I instruction word.
REQ-008 Port in_pc  in  PC_W  address of in_instr.
REQ-009 Port flush  in  1  discard all held instructions.
REQ-010 Port out_valid  out  1  a decoded instruction is presented.
REQ-011 Port out_ready  in  1  the consumer takes the decoded instruction.
REQ-012 Port out_opcode/out_funct3/out_funct7  out  7/3/7  instruction fields [6:0]/[14:12]/[31:25].
REQ-013 Port out_rs1/out_rs2/out_rd  out  5 each  register fields [19:15]/[24:20]/[11:7].
REQ-014 Port out_imm  out  XLEN  immediate, sign-extended to XLEN.
REQ-015 Port out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5.
REQ-016 Port out_illegal  out  1  the opcode is unsupported or in_instr[1:0] != 2'b11.
REQ-017 Port out_pc  out  PC_W  pc carried with the instruction.

Function
REQ-018 Decode SHALL be combinational on the input side; every decoded field SHALL be registered, giving a latency of exactly 1 cycle from acceptance to out_valid.
REQ-019 An input SHALL be accepted when in_valid and in_ready are both high; an output SHALL be consumed when out_valid and out_ready are both high.
REQ-020 The block SHALL hold a 2-entry buffer: a main output register plus one skid register.
REQ-021 in_ready SHALL be registered and SHALL equal the inverse of skid-occupied, so that in_ready never depends combinationally on out_ready.
REQ-022 Acceptance while the main register is empty, or is being consumed in the same cycle, SHALL load the main register; otherwise the accepted instruction SHALL load the skid register.
REQ-023 When the main register is consumed while the skid register is occupied, the skid contents SHALL move into the main register on the same edge and the skid register SHALL become empty.
REQ-024 Instructions SHALL leave the block in acceptance order; there SHALL be no loss and no duplication.
REQ-025 While out_valid is high and out_ready is low, all out_* fields SHALL remain stable.
REQ-026 Format decode: 0110011 -> R; 0010011, 0000011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; any other opcode -> illegal, with out_fmt = R and out_imm = 0.
REQ-027 Immediate layouts, each sign-extended from instr[31]:
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U: {instr[31:12], 12'b0}
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- R: imm = 0.
REQ-028 Illegal instructions SHALL flow through the buffer like any other instruction, with out_illegal = 1.
REQ-029 flush SHALL clear both valid bits on the next edge; an in_valid presented in the same cycle as flush SHALL be dropped.
REQ-030 in_ready SHALL be 1 in the cycle after flush.
REQ-031 flush and out_ready high in the same cycle: the current output counts as consumed, and no entry remains.

Reset
REQ-032 On rst, out_valid, the skid-valid bit and all out_* data fields SHALL be 0, and in_ready SHALL be 1, on the following edge.
REQ-033 rst SHALL take priority over flush and over any handshake, including a reset asserted mid-stall with both entries full.

Structure
REQ-034 A shared package SHALL hold the opcode constants, the fmt enumeration and the XLEN default.
REQ-035 Decode logic SHALL be a combinational sub-module, imm_gen, that takes instr and produces imm, fmt and illegal; it is instantiated once, on the input path.

Verification
REQ-036 Input 0xFFF10093 (addi x1,x2,-1) -> after 1 cycle: rd=1, rs1=2, fmt=I, imm=0xFFFFFFFF.
REQ-037 Input 0x123452B7 (lui x5) -> rd=5, fmt=U, imm=0x12345000; input 0xFFDFF0EF (jal x1,-4) -> fmt=J, imm=0xFFFFFFFC.
REQ-038 Input 0x00112223 (sw x1,4(x2)) -> fmt=S, imm=4, rs1=2, rs2=1.
REQ-039 Hold out_ready=0 for 3 cycles and offer A then B -> in_ready falls after B is accepted; on release, A then B are output on consecutive cycles; in_ready returns to 1.
REQ-040 Both entries full, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed instruction never appears at the output.
REQ-041 Input 0xFFFFFFFF, then rst asserted mid-stall -> out_illegal=1 while that instruction is presented; after reset, out_valid=0 and all outputs are 0.
